// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared encodings for the PC fetch sequencer: FSM state codes, PC stride and branch-take decode.
package pc_fetch_sequencer_pkg;

  typedef logic [1:0] seqState_t;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam int PC_INCR = 4;

  function automatic logic takeBranch(input logic branch, input logic aluZero, input logic uncond);
    return (branch && aluZero) || uncond;
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// Next-PC adder/mux: sequential stride or sign-extended branch offset, modulo 2^ADDR_W.
module next_pc_calc
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] CurrentPC,
  input  logic [ADDR_W-1:0] SignExtImm64,
  input  logic              Branch,
  input  logic              ALUZero,
  input  logic              Uncondbranch,
  output logic [ADDR_W-1:0] NextPC
);

  logic [ADDR_W-1:0] pcOffset;

  // Offset arrives pre-scaled from decode, so it is added without shifting.
  assign pcOffset = takeBranch(Branch, ALUZero, Uncondbranch) ? SignExtImm64 : ADDR_W'(PC_INCR);
  assign NextPC   = CurrentPC + pcOffset;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner: sequences fetch (req/ack with timeout), execute handshake and PC commit.
// state   | meaning
// S_LOAD  | load CurrentPC from StartPC after reset
// S_FETCH | IMemReq held until IMemAck or timeout
// S_EXEC  | Instr presented, waiting for ExecDone to commit
// S_HALT  | terminal after Halt commit or fetch timeout
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               CLK,
  input  logic               resetl,
  input  logic [ADDR_W-1:0]  StartPC,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemData,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  input  logic               ExecDone,
  input  logic               Branch,
  input  logic               ALUZero,
  input  logic               Uncondbranch,
  input  logic [ADDR_W-1:0]  SignExtImm64,
  input  logic               Halt,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic [31:0]        RetireCount,
  output logic               FetchErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seqState_t         state;
  logic [CNT_W-1:0]  toCnt;
  logic [ADDR_W-1:0] nextPC;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc_calc (
    .CurrentPC    (CurrentPC),
    .SignExtImm64 (SignExtImm64),
    .Branch       (Branch),
    .ALUZero      (ALUZero),
    .Uncondbranch (Uncondbranch),
    .NextPC       (nextPC)
  );

  // Handshake outputs decode from state so reset drops them without waiting for an edge.
  assign IMemReq    = (state == S_FETCH);
  assign InstrValid = (state == S_EXEC);
  assign IMemAddr   = CurrentPC;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= S_LOAD;
      CurrentPC   <= '0;
      Instr       <= '0;
      RetireCount <= '0;
      FetchErr    <= 1'b0;
      toCnt       <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          CurrentPC <= StartPC;
          toCnt     <= TO_LOAD;
          state     <= S_FETCH;
        end
        S_FETCH: begin
          // Ack in the final allowed cycle still beats the timeout.
          if (IMemAck) begin
            Instr <= IMemData;
            state <= S_EXEC;
          end else if (toCnt <= CNT_ONE) begin
            FetchErr <= 1'b1;
            state    <= S_HALT;
          end else begin
            toCnt <= toCnt - CNT_ONE;
          end
        end
        S_EXEC: begin
          if (ExecDone) begin
            CurrentPC   <= nextPC;
            RetireCount <= RetireCount + 32'd1;
            toCnt       <= TO_LOAD;
            state       <= Halt ? S_HALT : S_FETCH;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
